// File: rtl/axonerve_kvs_rtl_pkg.sv
// Shared definitions for the axonerve kvs vadd kernel control block.
// Holds the launch FSM state encoding and the interrupt status bit indices.
package axonerve_kvs_rtl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_RUN    = 2'd2
    } state_t;

    localparam int ISR_DONE  = 0;
    localparam int ISR_READY = 1;

endpackage

// File: rtl/axonerve_kvs_rtl_ap_ctrl.sv
// ap_ctrl handshake for the vadd datapath: launch FSM, status bits,
// interrupt status/line, run-cycle counter (saturating) and run counter.
// Ports:
//   aclk, areset             : clock, async active-high reset
//   ctrl_start_wr            : host AP_START write pulse
//   ctrl_auto_restart        : relaunch after each completion (level)
//   ctrl_done_rd             : host control-register read pulse
//   ctrl_gie, ctrl_ier       : global / per-source interrupt enables
//   ctrl_isr_toggle          : per-bit isr clear pulses
//   ap_start / ap_done       : datapath launch / completion pulses
//   stat_start/done/idle/ready, isr, interrupt : status to the host
//   cycle_count, run_count   : run length and completed-run counters
module axonerve_kvs_rtl_ap_ctrl
    import axonerve_kvs_rtl_pkg::*;
#(
    parameter int unsigned C_CYCLE_CNT_WIDTH = 64,
    parameter int unsigned C_RUN_CNT_WIDTH   = 32
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         ctrl_start_wr,
    input  logic                         ctrl_auto_restart,
    input  logic                         ctrl_done_rd,
    input  logic                         ctrl_gie,
    input  logic [1:0]                   ctrl_ier,
    input  logic [1:0]                   ctrl_isr_toggle,
    output logic                         ap_start,
    input  logic                         ap_done,
    output logic                         stat_start,
    output logic                         stat_done,
    output logic                         stat_idle,
    output logic                         stat_ready,
    output logic [1:0]                   isr,
    output logic                         interrupt,
    output logic [C_CYCLE_CNT_WIDTH-1:0] cycle_count,
    output logic [C_RUN_CNT_WIDTH-1:0]   run_count
);

    state_t                       r_state;
    state_t                       w_next;
    logic                         r_stat_start;
    logic                         r_stat_done;
    logic                         r_stat_idle;
    logic                         r_stat_ready;
    logic [1:0]                   r_isr;
    logic                         r_irq;
    logic [C_CYCLE_CNT_WIDTH-1:0] r_cyc;
    logic [C_RUN_CNT_WIDTH-1:0]   r_runs;
    logic                         w_done_acc;
    logic [1:0]                   w_isr_nxt;

    // Completion only counts while the datapath is actually running.
    assign w_done_acc = (r_state == ST_RUN) && ap_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   w_next = ctrl_start_wr ? ST_LAUNCH : ST_IDLE;
            ST_LAUNCH: w_next = ST_RUN;
            ST_RUN: begin
                if (ap_done) begin
                    w_next = ctrl_auto_restart ? ST_LAUNCH : ST_IDLE;
                end
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    // Set wins over a coincident toggle so no event is lost.
    always_comb begin
        w_isr_nxt = r_isr;
        w_isr_nxt[ISR_DONE] = (w_done_acc && ctrl_ier[ISR_DONE])
            || (r_isr[ISR_DONE] && !ctrl_isr_toggle[ISR_DONE]);
        w_isr_nxt[ISR_READY] = (r_stat_ready && ctrl_ier[ISR_READY])
            || (r_isr[ISR_READY] && !ctrl_isr_toggle[ISR_READY]);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_stat_start <= 1'b0;
            r_stat_done  <= 1'b0;
            r_stat_idle  <= 1'b1;
            r_stat_ready <= 1'b0;
            r_isr        <= 2'b00;
            r_irq        <= 1'b0;
            r_cyc        <= '0;
            r_runs       <= '0;
        end else begin
            r_state      <= w_next;
            r_stat_start <= (w_next != ST_IDLE);
            r_stat_idle  <= (w_next == ST_IDLE);
            r_stat_ready <= (r_state == ST_LAUNCH);
            r_isr        <= w_isr_nxt;
            // Driven from next isr so the line follows isr without lag.
            r_irq        <= ctrl_gie && (|w_isr_nxt);
            if (w_done_acc) begin
                r_stat_done <= 1'b1;
            end else if (ctrl_done_rd) begin
                r_stat_done <= 1'b0;
            end
            if (r_state == ST_LAUNCH) begin
                r_cyc <= '0;
            end else if (r_state == ST_RUN && r_cyc != '1) begin
                r_cyc <= r_cyc + C_CYCLE_CNT_WIDTH'(1);
            end
            if (w_done_acc) begin
                r_runs <= r_runs + C_RUN_CNT_WIDTH'(1);
            end
        end
    end

    assign ap_start    = (r_state == ST_LAUNCH);
    assign stat_start  = r_stat_start;
    assign stat_done   = r_stat_done;
    assign stat_idle   = r_stat_idle;
    assign stat_ready  = r_stat_ready;
    assign isr         = r_isr;
    assign interrupt   = r_irq;
    assign cycle_count = r_cyc;
    assign run_count   = r_runs;

endmodule

// File: tb/tb_axonerve_kvs_rtl_ap_ctrl.sv
// Self-checking bench for axonerve_kvs_rtl_ap_ctrl: directed scenarios
// plus randomized traffic against a cycle-level behavioural model.
module tb_axonerve_kvs_rtl_ap_ctrl;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        ctrl_start_wr = 1'b0;
    logic        ctrl_auto_restart = 1'b0;
    logic        ctrl_done_rd = 1'b0;
    logic        ctrl_gie = 1'b0;
    logic [1:0]  ctrl_ier = 2'b00;
    logic [1:0]  ctrl_isr_toggle = 2'b00;
    logic        ap_done = 1'b0;

    logic        ap_start, stat_start, stat_done, stat_idle, stat_ready;
    logic [1:0]  isr;
    logic        interrupt;
    logic [63:0] cycle_count;
    logic [31:0] run_count;

    logic        s_ap_start, s_stat_start, s_stat_done, s_stat_idle;
    logic        s_stat_ready, s_interrupt;
    logic [1:0]  s_isr;
    logic [3:0]  s_cycle_count;
    logic [31:0] s_run_count;

    int total = 0;
    int bad = 0;

    always #5 aclk = ~aclk;

    axonerve_kvs_rtl_ap_ctrl dut (
        .aclk(aclk), .areset(areset),
        .ctrl_start_wr(ctrl_start_wr),
        .ctrl_auto_restart(ctrl_auto_restart),
        .ctrl_done_rd(ctrl_done_rd), .ctrl_gie(ctrl_gie),
        .ctrl_ier(ctrl_ier), .ctrl_isr_toggle(ctrl_isr_toggle),
        .ap_start(ap_start), .ap_done(ap_done),
        .stat_start(stat_start), .stat_done(stat_done),
        .stat_idle(stat_idle), .stat_ready(stat_ready),
        .isr(isr), .interrupt(interrupt),
        .cycle_count(cycle_count), .run_count(run_count)
    );

    axonerve_kvs_rtl_ap_ctrl #(.C_CYCLE_CNT_WIDTH(4)) dut4 (
        .aclk(aclk), .areset(areset),
        .ctrl_start_wr(ctrl_start_wr),
        .ctrl_auto_restart(ctrl_auto_restart),
        .ctrl_done_rd(ctrl_done_rd), .ctrl_gie(ctrl_gie),
        .ctrl_ier(ctrl_ier), .ctrl_isr_toggle(ctrl_isr_toggle),
        .ap_start(s_ap_start), .ap_done(ap_done),
        .stat_start(s_stat_start), .stat_done(s_stat_done),
        .stat_idle(s_stat_idle), .stat_ready(s_stat_ready),
        .isr(s_isr), .interrupt(s_interrupt),
        .cycle_count(s_cycle_count), .run_count(s_run_count)
    );

    // Behavioural model: busy = a run is in flight (incl. launch cycle),
    // launch = this is the launch cycle. Counters kept as plain integers.
    bit          m_busy, m_launch, m_ready, m_done, m_irq;
    bit [1:0]    m_isr;
    longint      m_cyc;
    int unsigned m_runs;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_launch = 0; m_ready = 0; m_done = 0; m_irq = 0;
        m_isr = 2'b00; m_cyc = 0; m_runs = 0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        bit acc, nl, nb;
        bit [1:0] ni;
        acc = m_busy && !m_launch && ap_done;
        nl  = (!m_busy && ctrl_start_wr) || (acc && ctrl_auto_restart);
        nb  = nl || (m_busy && !acc);
        ni[0] = (acc && ctrl_ier[0]) ? 1'b1
              : (ctrl_isr_toggle[0] ? 1'b0 : m_isr[0]);
        ni[1] = (m_ready && ctrl_ier[1]) ? 1'b1
              : (ctrl_isr_toggle[1] ? 1'b0 : m_isr[1]);
        if (m_launch) m_cyc = 0;
        else if (m_busy) m_cyc++;
        if (acc) m_done = 1;
        else if (ctrl_done_rd) m_done = 0;
        if (acc) m_runs++;
        m_ready  = m_launch;
        m_launch = nl;
        m_busy   = nb;
        m_isr    = ni;
        m_irq    = ctrl_gie && (ni != 2'b00);
    endtask

    task automatic check_all();
        longint c4;
        c4 = (m_cyc > 15) ? 15 : m_cyc;
        chk("ap_start",   ap_start,    m_launch);
        chk("stat_start", stat_start,  m_busy);
        chk("stat_idle",  stat_idle,   !m_busy);
        chk("stat_ready", stat_ready,  m_ready);
        chk("stat_done",  stat_done,   m_done);
        chk("isr",        isr,         m_isr);
        chk("interrupt",  interrupt,   m_irq);
        chk("cycle_count", cycle_count, m_cyc);
        chk("run_count",  run_count,   m_runs);
        chk("cyc4",       s_cycle_count, c4);
        chk("start4",     s_ap_start,  m_launch);
    endtask

    // One cycle with the given pulses; called and returns at a negedge.
    task automatic cyc(input logic sw, input logic dn, input logic drd,
                       input logic [1:0] tog);
        ctrl_start_wr = sw; ap_done = dn;
        ctrl_done_rd = drd; ctrl_isr_toggle = tog;
        model_step();
        @(negedge aclk);
        ctrl_start_wr = 0; ap_done = 0;
        ctrl_done_rd = 0; ctrl_isr_toggle = 0;
        check_all();
    endtask

    task automatic do_reset(input int hold);
        ctrl_start_wr = 0; ap_done = 0;
        ctrl_done_rd = 0; ctrl_isr_toggle = 0;
        areset = 1;
        #1;
        model_reset();
        check_all();
        repeat (hold) @(negedge aclk);
        areset = 0;
        check_all();
    endtask

    int n_starts;
    int idle_hits;
    int unsigned r0;

    initial begin
        model_reset();
        repeat (3) @(negedge aclk);
        check_all();
        chk("rst_idle", stat_idle, 1);
        areset = 0;

        // Launch at cycle 10, done at cycle 30.
        repeat (9) cyc(0, 0, 0, 2'b00);
        cyc(1, 0, 0, 2'b00);
        chk("d37_start", ap_start, 1);
        repeat (19) cyc(0, 0, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        chk("d37_idle", stat_idle, 1);
        chk("d37_done", stat_done, 1);
        chk("d37_cyc", cycle_count, 19);
        chk("d37_runs", run_count, 1);
        chk("d42_sat", s_cycle_count, 4'hF);
        repeat (3) cyc(0, 0, 0, 2'b00);
        chk("d42_hold", s_cycle_count, 4'hF);
        cyc(0, 0, 1, 2'b00);
        chk("done_clr", stat_done, 0);

        // Three back-to-back auto-restarted runs.
        ctrl_auto_restart = 1;
        n_starts = 0; idle_hits = 0;
        cyc(1, 0, 0, 2'b00);
        n_starts += int'(ap_start);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 19; k++) begin
                cyc(0, 0, 0, 2'b00);
                idle_hits += int'(stat_idle);
                n_starts  += int'(ap_start);
            end
            if (r == 2) ctrl_auto_restart = 0;
            cyc(0, 1, 0, 2'b00);
            if (r < 2) idle_hits += int'(stat_idle);
            n_starts += int'(ap_start);
        end
        chk("d38_starts", n_starts, 3);
        chk("d38_idle", idle_hits, 0);
        chk("d38_runs", run_count, 4);
        chk("d38_end", stat_idle, 1);

        // Done interrupt, toggle clear, toggle coincident with done.
        ctrl_ier = 2'b01; ctrl_gie = 1;
        cyc(1, 0, 0, 2'b00);
        repeat (4) cyc(0, 0, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        chk("d39_isr", isr, 2'b01);
        chk("d39_irq", interrupt, 1);
        cyc(0, 0, 0, 2'b01);
        chk("d39_isr0", isr, 2'b00);
        chk("d39_irq0", interrupt, 0);
        cyc(1, 0, 0, 2'b00);
        repeat (3) cyc(0, 0, 0, 2'b00);
        cyc(0, 1, 0, 2'b01);
        chk("d39_keep", isr[0], 1);

        // Ignored start during RUN, spurious done in IDLE.
        cyc(0, 0, 0, 2'b01);
        r0 = run_count;
        cyc(1, 0, 0, 2'b00);
        n_starts = 0;
        for (int k = 0; k < 6; k++) begin
            cyc(k == 2, 0, 0, 2'b00);
            n_starts += int'(ap_start);
        end
        chk("d40_nostart", n_starts, 0);
        cyc(0, 1, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        cyc(0, 1, 0, 2'b00);
        chk("d40_runs", run_count, r0 + 1);

        // Reset mid-run, then a stale done.
        ctrl_ier = 2'b11;
        cyc(1, 0, 0, 2'b00);
        repeat (6) cyc(0, 0, 0, 2'b00);
        do_reset(2);
        cyc(0, 1, 0, 2'b00);
        chk("d41_runs", run_count, 0);
        chk("d41_idle", stat_idle, 1);
        chk("d41_isr", isr, 2'b00);
        cyc(0, 0, 0, 2'b00);
        chk("d41_nostart", ap_start, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                ctrl_auto_restart = 1'($urandom);
                ctrl_gie = 1'($urandom);
                ctrl_ier = 2'($urandom);
            end
            if ($urandom_range(0, 599) == 0) begin
                do_reset($urandom_range(1, 3));
            end else begin
                cyc($urandom_range(0, 7) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0,
                    {$urandom_range(0, 5) == 0,
                     $urandom_range(0, 5) == 0});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
